// File: rtl/alu_seq_exec.sv
// Execute-stage ALU behind a valid/ready handshake: logic and add/sub finish in one cycle,
// shifts iterate one bit per cycle, and the result is held until the consumer accepts it.
module alu_seq_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucon,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             err_q, err_d;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StDone;
          err_d   = 1'b0;
          case (alucon)
            OpAdd: acc_d = a + b;
            OpSub: acc_d = a - b;
            OpXor: acc_d = a ^ b;
            OpOr:  acc_d = a | b;
            OpAnd: acc_d = a & b;
            OpSll, OpSrl: begin
              acc_d  = a;
              cnt_d  = shamt;
              left_d = (alucon == OpSll);
              // A zero shift amount completes immediately with the operand unchanged.
              if (shamt != '0) state_d = StShift;
            end
            default: begin
              acc_d = '0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      StShift: begin
        acc_d = left_q ? (acc_q << 1) : (acc_q >> 1);
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    result    = acc_q;
    zero      = (acc_q == '0);
    err       = err_q;
  end

endmodule
